// File: rtl/cluster_power_seq.sv
// Cluster power/boot sequencer: walks the cluster through power, bypass release and
// reset release on a level request, and drains the cluster before powering it down.
module cluster_power_seq #(
  parameter int unsigned PWR_UP_CYCLES = 16,
  parameter int unsigned RST_CYCLES    = 8,
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pwr_req_i,
  input  logic [63:0] boot_addr_i,
  input  logic        cluster_busy_i,
  output logic        cluster_pow_o,
  output logic        cluster_byp_o,
  output logic        cluster_rstn_o,
  output logic        cluster_fetch_enable_o,
  output logic [63:0] cluster_boot_addr_o,
  output logic [2:0]  state_o,
  output logic        ready_o,
  output logic        evt_o,
  output logic        timeout_o
);

  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_PWR_UP   = 3'd1;
  localparam logic [2:0] S_RST_HOLD = 3'd2;
  localparam logic [2:0] S_RUN      = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_PWR_DN   = 3'd5;

  localparam logic [CNT_W-1:0] PWR_UP_LOAD = CNT_W'(PWR_UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD  = CNT_W'(DRAIN_TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pow;
  logic             r_byp;
  logic             r_rstn;
  logic             r_fetch;
  logic             r_ready;
  logic             r_evt;
  logic             r_timeout;
  logic [63:0]      r_boot_addr;

  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_accept;
  logic             w_set_timeout;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  // Request semantics: pwr_req_i is a level, not a valid/ready pulse. It is only
  // sampled in OFF (power-up) and RUN (power-down); ready_o marks RUN, where a
  // dropped request is honoured. Every other state runs to completion.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt;
    w_accept      = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_OFF: begin
        if (pwr_req_i) begin
          w_next_state = S_PWR_UP;
          w_next_cnt   = PWR_UP_LOAD;
          w_accept     = 1'b1;
        end
      end
      S_PWR_UP: begin
        if (w_cnt_zero) begin
          w_next_state = S_RST_HOLD;
          w_next_cnt   = RST_LOAD;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      S_RST_HOLD: begin
        if (w_cnt_zero) begin
          w_next_state = S_RUN;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      S_RUN: begin
        if (!pwr_req_i) begin
          w_next_state = S_DRAIN;
          w_next_cnt   = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        // Busy low wins over an expiring timer in the same cycle.
        if (!cluster_busy_i) begin
          w_next_state = S_PWR_DN;
          w_next_cnt   = RST_LOAD;
        end else if (w_cnt_zero) begin
          w_next_state  = S_PWR_DN;
          w_next_cnt    = RST_LOAD;
          w_set_timeout = 1'b1;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      S_PWR_DN: begin
        if (w_cnt_zero) begin
          w_next_state = S_OFF;
        end else begin
          w_next_cnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_next_state = S_OFF;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_OFF;
      r_cnt       <= '0;
      r_pow       <= 1'b0;
      r_byp       <= 1'b1;
      r_rstn      <= 1'b0;
      r_fetch     <= 1'b0;
      r_ready     <= 1'b0;
      r_evt       <= 1'b0;
      r_timeout   <= 1'b0;
      r_boot_addr <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_pow   <= (w_next_state != S_OFF);
      r_byp   <= (w_next_state == S_OFF) || (w_next_state == S_PWR_UP) ||
                 (w_next_state == S_PWR_DN);
      r_rstn  <= (w_next_state == S_RUN) || (w_next_state == S_DRAIN);
      r_fetch <= (w_next_state == S_RUN);
      r_ready <= (w_next_state == S_RUN);
      r_evt   <= ((w_next_state == S_RUN) && (r_state != S_RUN)) ||
                 ((w_next_state == S_OFF) && (r_state == S_PWR_DN));
      if (w_accept) begin
        r_boot_addr <= boot_addr_i;
        r_timeout   <= 1'b0;
      end else if (w_set_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign state_o                = r_state;
  assign cluster_pow_o          = r_pow;
  assign cluster_byp_o          = r_byp;
  assign cluster_rstn_o         = r_rstn;
  assign cluster_fetch_enable_o = r_fetch;
  assign cluster_boot_addr_o    = r_boot_addr;
  assign ready_o                = r_ready;
  assign evt_o                  = r_evt;
  assign timeout_o              = r_timeout;

endmodule

// File: tb/tb_cluster_power_seq.sv
// Bench for cluster_power_seq: directed sequence followed by randomized request/busy
// traffic, all checked every cycle against a timeline-based reference model.
module tb_cluster_power_seq;

  localparam int PU = 16;
  localparam int RC = 8;
  localparam int DT = 1024;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        rst_i;
  logic        pwr_req_i;
  logic [63:0] boot_addr_i;
  logic        cluster_busy_i;
  logic        cluster_pow_o;
  logic        cluster_byp_o;
  logic        cluster_rstn_o;
  logic        cluster_fetch_enable_o;
  logic [63:0] cluster_boot_addr_o;
  logic [2:0]  state_o;
  logic        ready_o;
  logic        evt_o;
  logic        timeout_o;

  cluster_power_seq #(
    .PWR_UP_CYCLES(PU),
    .RST_CYCLES(RC),
    .DRAIN_TIMEOUT(DT),
    .CNT_W(16)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .pwr_req_i(pwr_req_i),
    .boot_addr_i(boot_addr_i),
    .cluster_busy_i(cluster_busy_i),
    .cluster_pow_o(cluster_pow_o),
    .cluster_byp_o(cluster_byp_o),
    .cluster_rstn_o(cluster_rstn_o),
    .cluster_fetch_enable_o(cluster_fetch_enable_o),
    .cluster_boot_addr_o(cluster_boot_addr_o),
    .state_o(state_o),
    .ready_o(ready_o),
    .evt_o(evt_o),
    .timeout_o(timeout_o)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // Phases with elapsed time since phase entry; the boot phase covers both the
  // power-up and reset-hold windows and is split only when deriving outputs.
  localparam int M_IDLE  = 0;
  localparam int M_BOOT  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;
  localparam int M_STOP  = 4;

  int          m_mode = M_IDLE;
  int          m_age  = 0;
  logic [63:0] m_addr = '0;
  logic        m_to   = 1'b0;
  logic        m_evt  = 1'b0;

  task automatic model_edge();
    m_evt = 1'b0;
    if (rst_i) begin
      m_mode = M_IDLE;
      m_age  = 0;
      m_addr = '0;
      m_to   = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (pwr_req_i) begin
          m_mode = M_BOOT; m_age = 0; m_addr = boot_addr_i; m_to = 1'b0;
        end
        M_BOOT: begin
          m_age++;
          if (m_age == PU + RC) begin m_mode = M_RUN; m_evt = 1'b1; end
        end
        M_RUN: if (!pwr_req_i) begin m_mode = M_DRAIN; m_age = 0; end
        M_DRAIN: begin
          if (!cluster_busy_i) begin
            m_mode = M_STOP; m_age = 0;
          end else if (m_age + 1 == DT) begin
            m_mode = M_STOP; m_age = 0; m_to = 1'b1;
          end else begin
            m_age++;
          end
        end
        default: begin
          m_age++;
          if (m_age == RC) begin m_mode = M_IDLE; m_evt = 1'b1; end
        end
      endcase
    end
  endtask

  function automatic logic [9:0] model_status();
    logic [2:0] st;
    logic pow, byp, rstn, fetch;
    case (m_mode)
      M_IDLE:  st = 3'd0;
      M_BOOT:  st = (m_age < PU) ? 3'd1 : 3'd2;
      M_RUN:   st = 3'd3;
      M_DRAIN: st = 3'd4;
      default: st = 3'd5;
    endcase
    pow   = (m_mode != M_IDLE);
    byp   = (m_mode == M_IDLE) || (m_mode == M_STOP) || (st == 3'd1);
    rstn  = (m_mode == M_RUN) || (m_mode == M_DRAIN);
    fetch = (m_mode == M_RUN);
    return {st, pow, byp, rstn, fetch, fetch, m_evt, m_to};
  endfunction

  // ---------------- scoreboard ----------------
  logic [9:0]  exp_q[$];
  logic [63:0] addr_q[$];

  task automatic step(input int n);
    logic [9:0]  obs;
    logic [9:0]  e;
    logic [63:0] ea;
    repeat (n) begin
      model_edge();
      exp_q.push_back(model_status());
      addr_q.push_back(m_addr);
      @(posedge clk_i);
      @(negedge clk_i);
      obs = {state_o, cluster_pow_o, cluster_byp_o, cluster_rstn_o,
             cluster_fetch_enable_o, ready_o, evt_o, timeout_o};
      e  = exp_q.pop_front();
      ea = addr_q.pop_front();
      checks++;
      assert (obs === e) else begin
        errors++;
        $error("FAIL status obs=%b exp=%b at %0t", obs, e, $time);
      end
      checks++;
      assert (cluster_boot_addr_o === ea) else begin
        errors++;
        $error("FAIL boot_addr obs=%h exp=%h at %0t", cluster_boot_addr_o, ea, $time);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  int req_len;
  int busy_len;

  initial begin
    rst_i = 1'b1; pwr_req_i = 1'b0; boot_addr_i = '0; cluster_busy_i = 1'b0;
    step(2);
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_byp", 64'(cluster_byp_o), 64'd1);
    chk("rst_addr", cluster_boot_addr_o, 64'd0);

    // T1: power-up latency
    rst_i = 1'b0; pwr_req_i = 1'b1; boot_addr_i = 64'h1C00_8080;
    step(1);
    chk("t1_pow_c1", 64'(cluster_pow_o), 64'd1);
    step(15);
    chk("t1_byp_c16", 64'(cluster_byp_o), 64'd1);
    step(1);
    chk("t1_byp_c17", 64'(cluster_byp_o), 64'd0);
    step(7);
    chk("t1_rstn_c24", 64'(cluster_rstn_o), 64'd0);
    step(1);
    chk("t1_fetch_c25", 64'(cluster_fetch_enable_o), 64'd1);
    chk("t1_evt_c25", 64'(evt_o), 64'd1);
    chk("t1_addr", cluster_boot_addr_o, 64'h1C00_8080);

    // T2: boot address stable in RUN
    boot_addr_i = '0;
    step(3);
    chk("t2_addr", cluster_boot_addr_o, 64'h1C00_8080);

    // T3: drain with busy released after 5 cycles
    cluster_busy_i = 1'b1; pwr_req_i = 1'b0;
    step(1);
    chk("t3_fetch", 64'(cluster_fetch_enable_o), 64'd0);
    step(4);
    chk("t3_drain", 64'(state_o), 64'd4);
    cluster_busy_i = 1'b0;
    step(1);
    chk("t3_pwrdn", 64'(state_o), 64'd5);
    step(7);
    chk("t3_pow_hold", 64'(cluster_pow_o), 64'd1);
    step(1);
    chk("t3_pow_off", 64'(cluster_pow_o), 64'd0);
    chk("t3_evt", 64'(evt_o), 64'd1);
    chk("t3_timeout", 64'(timeout_o), 64'd0);

    // T4: drain timeout
    pwr_req_i = 1'b1; boot_addr_i = 64'hDEAD_BEEF_0000_1234;
    step(25);
    chk("t4_run", 64'(state_o), 64'd3);
    cluster_busy_i = 1'b1; pwr_req_i = 1'b0;
    step(1024);
    chk("t4_drain_end", 64'(state_o), 64'd4);
    step(1);
    chk("t4_pwrdn", 64'(state_o), 64'd5);
    chk("t4_timeout", 64'(timeout_o), 64'd1);
    step(8);
    chk("t4_off_sticky", 64'(timeout_o), 64'd1);
    pwr_req_i = 1'b1; cluster_busy_i = 1'b0;
    step(1);
    chk("t4_clear", 64'(timeout_o), 64'd0);

    // T5: request dropped during power-up
    step(2);
    pwr_req_i = 1'b0;
    step(22);
    chk("t5_run", 64'(state_o), 64'd3);
    step(1);
    chk("t5_drain", 64'(state_o), 64'd4);
    step(9);
    chk("t5_off", 64'(state_o), 64'd0);

    // T6: reset in RUN
    pwr_req_i = 1'b1;
    step(25);
    chk("t6_run", 64'(state_o), 64'd3);
    step(5);
    rst_i = 1'b1;
    step(1);
    chk("t6_state", 64'(state_o), 64'd0);
    chk("t6_evt", 64'(evt_o), 64'd0);
    chk("t6_byp", 64'(cluster_byp_o), 64'd1);
    chk("t6_addr", cluster_boot_addr_o, 64'd0);
    rst_i = 1'b0; pwr_req_i = 1'b0;
    step(2);

    // Randomized traffic
    req_len = 0;
    busy_len = 0;
    for (int i = 0; i < 3000; i++) begin
      if (req_len == 0) begin
        pwr_req_i = ~pwr_req_i;
        req_len = $urandom_range(1, 80);
      end
      req_len--;
      if (busy_len == 0) begin
        cluster_busy_i = ~cluster_busy_i;
        busy_len = $urandom_range(1, 30);
      end
      busy_len--;
      boot_addr_i = {$urandom, $urandom};
      rst_i = ($urandom_range(0, 599) == 0);
      step(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
